// File: rtl/mem_pkg.sv
// Shared types and sizes for the load/store unit and its data memory.
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } lsu_state_t;
endpackage

// File: rtl/load_store_unit.sv
// Load/store sequencer: forms base+offset, issues one or two byte accesses
// (little-endian) to data_memory and returns load data with a done pulse.
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  start,
  input  logic                  req,
  input  logic                  op_write,
  input  logic                  op_wide,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     offset,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [2*DATA_W-1:0]   rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  import mem_pkg::*;

  lsu_state_t            r_state;
  lsu_state_t            w_next_state;
  logic [ADDR_W-1:0]     r_ea;
  logic [2*DATA_W-1:0]   r_wdata;
  logic                  r_write;
  logic                  r_wide;
  logic [2*DATA_W-1:0]   r_rdata;
  logic                  w_accept;
  logic                  w_write_raw;
  logic [ADDR_W-1:0]     w_ea_sum;
  logic [ADDR_W-1:0]     w_ea_hi;

  // Carry out of the adders is discarded so addresses wrap modulo 2^ADDR_W.
  assign w_ea_sum = base_addr + offset;
  assign w_ea_hi  = r_ea + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    mem_read     = 1'b0;
    w_write_raw  = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_accept     = 1'b1;
          w_next_state = ACC0;
        end
      end
      ACC0: begin
        busy         = 1'b1;
        mem_address  = r_ea;
        mem_read     = ~r_write;
        w_write_raw  = r_write;
        mem_wdata    = r_write ? r_wdata[DATA_W-1:0] : '0;
        w_next_state = r_wide ? ACC1 : DONE;
      end
      ACC1: begin
        busy         = 1'b1;
        mem_address  = w_ea_hi;
        mem_read     = ~r_write;
        w_write_raw  = r_write;
        mem_wdata    = r_write ? r_wdata[2*DATA_W-1:DATA_W] : '0;
        w_next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (req) begin
          w_accept     = 1'b1;
          w_next_state = ACC0;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Reset also masks the write strobe so data_memory init cannot be overwritten.
  assign mem_write = w_write_raw & ~start;
  assign rdata     = r_rdata;

  always_ff @(posedge clock) begin
    if (start) begin
      r_state <= IDLE;
      r_ea    <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_wide  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_ea    <= w_ea_sum;
        r_wdata <= wdata;
        r_write <= op_write;
        r_wide  <= op_wide;
      end
      if (r_state == ACC0 && !r_write) begin
        r_rdata[DATA_W-1:0] <= mem_rdata;
        if (!r_wide) r_rdata[2*DATA_W-1:DATA_W] <= '0;
      end
      if (r_state == ACC1 && !r_write) begin
        r_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
      end
    end
  end
endmodule
